// File: rtl/modinv_pkg.sv
// modinv_pkg: shared FSM state type and latency bound for the binary modular-inverse unit.
package modinv_pkg;
    typedef enum logic [1:0] {IDLE, CHECK, LOOP, DONE} state_e;

    function automatic int unsigned lat_max(input int unsigned w);
        return 4 * w + 4;
    endfunction
endpackage

// File: rtl/mod_half.sv
// mod_half: halves x modulo odd m, adding m first when x is odd; W+1-bit sum so it never overflows.
module mod_half #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] y_o
);
    logic [W:0] sum;

    assign sum = {1'b0, x_i} + (x_i[0] ? {1'b0, m_i} : '0);
    assign y_o = sum[W:1];
endmodule

// File: rtl/binary_mod_inverse.sv
// binary_mod_inverse: sequential a^-1 mod m via the binary extended Euclidean algorithm (odd m).
// Define MODINV_GCD_OUT_EN to add the gcd_out port.
module binary_mod_inverse
    import modinv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] inv,
    output logic         invertible,
    output logic         bad_arg
`ifdef MODINV_GCD_OUT_EN
    ,
    output logic [W-1:0] gcd_out
`endif
);
    state_e       state_q, state_d;
    logic [W-1:0] a_q, a_d, m_q, m_d, u_q, u_d, v_q, v_d;
    logic [W-1:0] x1_q, x1_d, x2_q, x2_d, inv_q, inv_d;
    logic         ok_q, ok_d, bad_q, bad_d;
    logic [W-1:0] gcd_q, gcd_d;
    logic [W-1:0] x1_h, x2_h, d12, d21;

    mod_half #(.W(W)) u_half1 (.x_i(x1_q), .m_i(m_q), .y_o(x1_h));
    mod_half #(.W(W)) u_half2 (.x_i(x2_q), .m_i(m_q), .y_o(x2_h));

    // Wrapping W-bit differences; adding m back lands in [0, m) when the raw difference went negative.
    assign d12 = x1_q - x2_q;
    assign d21 = x2_q - x1_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        inv_d   = inv_q;
        ok_d    = ok_q;
        bad_d   = bad_q;
        gcd_d   = gcd_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = CHECK;
                a_d     = a;
                m_d     = m;
                inv_d   = '0;
                ok_d    = 1'b0;
                bad_d   = 1'b0;
                gcd_d   = '0;
            end
            CHECK: if (!m_q[0] || m_q == W'(1) || a_q >= m_q) begin
                state_d = DONE;
                bad_d   = 1'b1;
            end else begin
                state_d = LOOP;
                u_d     = a_q;
                v_d     = m_q;
                x1_d    = W'(1);
                x2_d    = '0;
            end
            LOOP: if (u_q == '0) begin
                state_d = DONE;
                ok_d    = v_q == W'(1);
                inv_d   = v_q == W'(1) ? x2_q : '0;
                gcd_d   = v_q;
            end else if (!u_q[0]) begin
                u_d  = u_q >> 1;
                x1_d = x1_h;
            end else if (!v_q[0]) begin
                v_d  = v_q >> 1;
                x2_d = x2_h;
            end else if (u_q >= v_q) begin
                u_d  = u_q - v_q;
                x1_d = x1_q >= x2_q ? d12 : d12 + m_q;
            end else begin
                v_d  = v_q - u_q;
                x2_d = x2_q >= x1_q ? d21 : d21 + m_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            inv_q   <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
            gcd_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            inv_q   <= inv_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
            gcd_q   <= gcd_d;
        end
    end

    assign busy       = state_q == CHECK || state_q == LOOP;
    assign done       = state_q == DONE;
    assign inv        = inv_q;
    assign invertible = ok_q;
    assign bad_arg    = bad_q;
`ifdef MODINV_GCD_OUT_EN
    assign gcd_out    = gcd_q;
`else
    logic unused_gcd;
    assign unused_gcd = ^gcd_q;
`endif
endmodule

// File: tb/tb_binary_mod_inverse.sv
// tb_binary_mod_inverse: scoreboard bench; reference results come from a classic extended-Euclid model.
module tb_binary_mod_inverse;
    import modinv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] a_in = '0, m_in = '0;
    logic         busy, done, invertible, bad_arg;
    logic [W-1:0] inv;
`ifdef MODINV_GCD_OUT_EN
    logic [W-1:0] gcd_out;
`endif

    typedef struct {
        logic [W-1:0] a, m, inv, gcd;
        logic         ok, bad;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    binary_mod_inverse #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .m(m_in),
        .busy(busy), .done(done), .inv(inv), .invertible(invertible), .bad_arg(bad_arg)
`ifdef MODINV_GCD_OUT_EN
        , .gcd_out(gcd_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] m, output exp_t e);
        longint r0, r1, t0, t1, q, tmp;
        e = '{a: a, m: m, inv: '0, gcd: '0, ok: 1'b0, bad: 1'b0};
        if (!m[0] || m == 1 || a >= m) begin
            e.bad = 1'b1;
        end else begin
            r0 = longint'(m); r1 = longint'(a); t0 = 0; t1 = 1;
            while (r1 != 0) begin
                q = r0 / r1;
                tmp = r0 - q * r1; r0 = r1; r1 = tmp;
                tmp = t0 - q * t1; t0 = t1; t1 = tmp;
            end
            e.gcd = W'(r0);
            if (r0 == 1) begin
                e.ok  = 1'b1;
                e.inv = W'(t0 < 0 ? t0 + longint'(m) : t0);
            end
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] m, input bit noise);
        exp_t e;
        int   lat;
        model(a, m, e);
        sb.push_back(e);
        @(negedge clk);
        a_in  = a;
        m_in  = m;
        start = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            start = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                a_in = $urandom;
                m_in = $urandom | 1;
            end
        end while (!done && lat < int'(lat_max(W)) + 8);
        e = sb.pop_front();
        check("done_seen", done, 1);
        check("inv", inv, e.inv);
        check("invertible", invertible, e.ok);
        check("bad_arg", bad_arg, e.bad);
`ifdef MODINV_GCD_OUT_EN
        check("gcd_out", gcd_out, e.gcd);
`endif
        check("busy_at_done", busy, 0);
        if (e.bad) check("bad_latency", lat, 2);
        else check("latency_bound", 64'(lat <= int'(lat_max(W))), 1);
        if (e.ok) check("inv_times_a", (64'(inv) * 64'(a)) % 64'(m), 1);
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", {busy, done}, 0);
        check("held_inv", inv, e.inv);
    endtask

    initial begin
        logic [W-1:0] rm, ra;
        bit           seen;
        repeat (3) @(negedge clk);
        check("reset_outputs", {inv, invertible, bad_arg, busy, done}, 0);
`ifdef MODINV_GCD_OUT_EN
        check("reset_gcd", gcd_out, 0);
`endif
        rst = 1'b0;

        do_op(3, 7, 0);
        do_op(10, 17, 0);
        do_op(6, 9, 0);
        do_op(3, 8, 0);
        do_op(0, 1, 0);
        do_op(9, 7, 0);
        do_op(2, 32'hFFFF_FFFB, 0);
        do_op(0, 11, 0);
        do_op(10, 17, 1);
        do_op(6, 9, 1);

        @(negedge clk);
        a_in  = 2;
        m_in  = 32'hFFFF_FFFB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_mid_loop", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {inv, invertible, bad_arg, busy, done}, 0);
        @(negedge clk);
        check("rst_edge_outputs", {inv, invertible, bad_arg, busy, done}, 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= done;
        end
        check("no_done_after_rst", seen, 0);
        do_op(2, 32'hFFFF_FFFB, 0);

        for (int i = 0; i < 40; i++) begin
            rm = W'($urandom_range(3, 65535)) | 1;
            ra = W'($urandom_range(0, int'(rm) - 1));
            do_op(ra, rm, i[0]);
        end
        for (int i = 0; i < 6; i++) begin
            rm = $urandom | 32'h8000_0001;
            ra = $urandom % rm;
            do_op(ra, rm, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
